// File: rtl/req_cond_pkg.sv
// rtl/req_cond_pkg.sv - shared types, range limits and width helper for req_conditioner
// Purpose: FSM state encoding, legal parameter minimums and counter width helper.
// Ports: none (package).
package req_cond_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PRESS   = 2'b01,
    HELD    = 2'b10,
    RELEASE = 2'b11
  } state_t;

  localparam int MIN_SYNC_STAGES     = 2;
  localparam int MIN_DEBOUNCE_CYCLES = 1;
  localparam int MIN_REPEAT_PERIOD   = 2;

  // Wide enough to hold the larger of the debounce and repeat terminal counts.
  function automatic int cnt_width(input int debounce, input int repeat_period);
    return $clog2((debounce > repeat_period) ? debounce : repeat_period) + 1;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - multi-flop synchroniser for one asynchronous bit
// Purpose: brings an asynchronous level into the clk domain.
// Ports:
//   clk  in  clock
//   rst  in  synchronous active-high reset, clears every stage
//   d    in  asynchronous input level
//   q    out last synchroniser stage
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/req_conditioner.sv
// rtl/req_conditioner.sv - synchronise, debounce and pulse-convert a raw request line
// Purpose: turns a bouncy asynchronous request into one req_pulse per accepted press.
// Optional feature: define REQ_AUTOREPEAT_EN to emit repeat pulses every
//   REPEAT_PERIOD cycles while the request stays held.
// Ports:
//   clk        in  clock
//   rst        in  synchronous active-high reset
//   raw_in     in  asynchronous raw request level
//   req_pulse  out one-cycle accepted-press pulse
//   level_out  out debounced registered level
//   busy       out high while a debounce window is open (PRESS or RELEASE)
module req_conditioner
  import req_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic req_pulse,
  output logic level_out,
  output logic busy
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
    $error("req_conditioner: SYNC_STAGES below minimum");
  end
  if (DEBOUNCE_CYCLES < MIN_DEBOUNCE_CYCLES) begin : g_bad_debounce
    $error("req_conditioner: DEBOUNCE_CYCLES below minimum");
  end
  if (REPEAT_PERIOD < MIN_REPEAT_PERIOD) begin : g_bad_repeat
    $error("req_conditioner: REPEAT_PERIOD below minimum");
  end

  logic             s_in;
  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d, cnt_sat;
  logic             level_d, pulse_d;

`ifdef REQ_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_PERIOD - 1);
  logic [CNT_W-1:0] rcnt, rcnt_d;
`endif

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (raw_in),
    .q   (s_in)
  );

  // The sample that opens a window counts as the first stable cycle (cnt=0),
  // so a window closes once cnt reaches DEBOUNCE_CYCLES-1.
  assign cnt_sat = (cnt == CNT_LAST) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      level_out <= 1'b0;
      req_pulse <= 1'b0;
`ifdef REQ_AUTOREPEAT_EN
      rcnt      <= '0;
`endif
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      level_out <= level_d;
      req_pulse <= pulse_d;
`ifdef REQ_AUTOREPEAT_EN
      rcnt      <= rcnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    level_d = level_out;
    pulse_d = 1'b0;
`ifdef REQ_AUTOREPEAT_EN
    rcnt_d  = rcnt;
`endif
    case (state)
      IDLE: begin
        if (s_in) begin
          // A one-cycle window is already satisfied by the opening sample.
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = HELD;
            level_d = 1'b1;
            pulse_d = 1'b1;
`ifdef REQ_AUTOREPEAT_EN
            rcnt_d  = '0;
`endif
          end else begin
            state_d = PRESS;
            cnt_d   = '0;
          end
        end
      end
      PRESS: begin
        if (!s_in) begin
          state_d = IDLE;
        end else if (cnt_sat == CNT_LAST) begin
          state_d = HELD;
          level_d = 1'b1;
          pulse_d = 1'b1;
`ifdef REQ_AUTOREPEAT_EN
          rcnt_d  = '0;
`endif
        end else begin
          cnt_d = cnt_sat;
        end
      end
      HELD: begin
        if (!s_in) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = IDLE;
            level_d = 1'b0;
          end else begin
            state_d = RELEASE;
            cnt_d   = '0;
          end
        end else begin
`ifdef REQ_AUTOREPEAT_EN
          if (rcnt == RPT_LAST) begin
            pulse_d = 1'b1;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt + CNT_W'(1);
          end
`endif
        end
      end
      RELEASE: begin
        if (s_in) begin
          state_d = HELD;
`ifdef REQ_AUTOREPEAT_EN
          rcnt_d  = '0;
`endif
        end else if (cnt_sat == CNT_LAST) begin
          state_d = IDLE;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_sat;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state == PRESS) || (state == RELEASE);

endmodule

// File: tb/tb_req_conditioner.sv
// tb/tb_req_conditioner.sv - self-checking bench for req_conditioner
module tb_req_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int RPT  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic raw_in = 1'b1;
  logic req_pulse, level_out, busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  req_conditioner #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_PERIOD   (RPT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .raw_in    (raw_in),
    .req_pulse (req_pulse),
    .level_out (level_out),
    .busy      (busy)
  );

  // Reference: the FSM samples raw_in as it was SYNC edges earlier; the
  // accepted level flips after DEB consecutive samples disagreeing with it.
  logic hist [SYNC];
  logic m_level = 1'b0;
  logic m_pulse = 1'b0;
  logic m_busy  = 1'b0;
  int   m_run   = 0;
  int   m_rc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic s;
    if (rst) begin
      for (int i = 0; i < SYNC; i++) hist[i] = 1'b0;
      m_level = 1'b0;
      m_run   = 0;
      m_rc    = 0;
      m_pulse = 1'b0;
    end else begin
      s = hist[SYNC-1];
      for (int i = SYNC-1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = raw_in;
      m_pulse = 1'b0;
      if (s != m_level) begin
        m_run++;
        if (m_run == DEB) begin
          m_level = s;
          m_run   = 0;
          if (s) begin
            m_pulse = 1'b1;
            m_rc    = 0;
          end
        end
      end else begin
`ifdef REQ_AUTOREPEAT_EN
        if (m_level) begin
          if (m_run != 0) m_rc = 0;
          else if (m_rc == RPT-1) begin
            m_pulse = 1'b1;
            m_rc    = 0;
          end else m_rc++;
        end
`endif
        m_run = 0;
      end
    end
    m_busy = (m_run != 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("model", {29'd0, req_pulse, level_out, busy}, {29'd0, m_pulse, m_level, m_busy});
  endtask

  task automatic idle(input int n);
    raw_in = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Ticks until req_pulse is seen; n is the 1-based tick index, -1 if none.
  task automatic wait_pulse(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (req_pulse === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  typedef struct {
    logic rst;
    logic raw;
    logic pulse;
    logic level;
    logic busy;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int n, pulses, lvl_min, busy_seen, run_len;
    logic val;
    int got[$];
    int exp_rep[4];

    for (int i = 0; i < SYNC; i++) hist[i] = 1'b0;

    // Reset with raw_in high, release, clean press held 20 cycles, release.
    for (int i = 0; i < 3; i++) tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b0});
    for (int i = 6; i < 20; i++) tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
`ifdef REQ_AUTOREPEAT_EN
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
`else
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
`endif
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      rst    = tbl[i].rst;
      raw_in = tbl[i].raw;
      tick();
      check($sformatf("table[%0d]", i), {29'd0, req_pulse, level_out, busy},
            {29'd0, tbl[i].pulse, tbl[i].level, tbl[i].busy});
    end

    // Bounce: 2-cycle runs are rejected, then a stable rise pulses after 6 ticks.
    idle(12);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      raw_in = ((i / 2) % 2 == 0);
      tick();
      if (req_pulse === 1'b1) pulses++;
    end
    check("bounce_no_pulse", pulses, 0);
    raw_in = 1'b1;
    wait_pulse(20, n);
    check("bounce_latency", n, 6);

    // Release bounce while held: level stays, no extra pulse.
    for (int i = 0; i < 3; i++) tick();
    raw_in = 1'b0;
    tick();
    tick();
    raw_in = 1'b1;
    pulses = 0; lvl_min = 1; busy_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (req_pulse === 1'b1) pulses++;
      if (level_out !== 1'b1) lvl_min = 0;
      if (busy === 1'b1) busy_seen = 1;
    end
    check("rel_bounce_pulses", pulses, 0);
    check("rel_bounce_level", lvl_min, 1);
    check("rel_bounce_busy", busy_seen, 1);

    // Reset in the middle of PRESS discards progress.
    idle(12);
    raw_in = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("midrst_busy_before", busy, 1);
    rst = 1'b1;
    tick();
    check("midrst_outputs", {29'd0, req_pulse, level_out, busy}, 32'd0);
    rst = 1'b0;
    wait_pulse(20, n);
    check("midrst_latency", n, 6);

`ifdef REQ_AUTOREPEAT_EN
    idle(12);
    raw_in = 1'b1;
    exp_rep = '{6, 22, 38, 54};
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (req_pulse === 1'b1) got.push_back(i);
    end
    check("repeat_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      check($sformatf("repeat_t[%0d]", i), got[i], exp_rep[i]);
`else
    exp_rep = '{0, 0, 0, 0};
    got.delete();
`endif

    // Random runs of varying length with occasional resets, checked by the model.
    idle(12);
    val = 1'b0;
    for (int r = 0; r < 400; r++) begin
      val = ~val;
      raw_in = val;
      run_len = $urandom_range(1, 10);
      for (int i = 0; i < run_len; i++) begin
        rst = ($urandom_range(0, 99) == 0);
        tick();
      end
      rst = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
